ex_md_stage: RTL and testbench

EX_MD_STAGE -- requirements
Module: ex_md_stage

---
 rtl/ex_md_stage_if.sv | 49 ++++
 rtl/ex_md_stage.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ex_md_stage.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_md_stage_if.sv
// ex_md_stage_if
// Bundles the E-stage instruction fields entering the execute / multiply-
// divide stage together with the registered E/M outputs it returns.
//   master : the pipeline control side. It drives the E-stage operands,
//            forwarding selects and opcodes, and receives the E/M register,
//            md_busy and md_stall.
//   slave  : the ex_md_stage itself.
interface ex_md_stage_if #(
    parameter int W = 32
);
    logic         valid_e;
    logic         flush;
    logic [W-1:0] rs_e;
    logic [W-1:0] rt_e;
    logic [W-1:0] ext_e;
    logic [4:0]   shamt;
    logic [W-1:0] fwd_d1;
    logic [W-1:0] fwd_d2;
    logic [W-1:0] fwd_d3;
    logic [1:0]   rs_fwd;
    logic [1:0]   rt_fwd;
    logic         alu_asel;
    logic         alu_bsel;
    logic [3:0]   alu_op;
    logic         ov_chk;
    logic [3:0]   md_op;
    logic [4:0]   exc_e;

    logic [W-1:0] ao_m;
    logic [W-1:0] rt_m;
    logic [4:0]   exc_m;
    logic         valid_m;
    logic         md_busy;
    logic         md_stall;

    modport master (
        output valid_e, flush, rs_e, rt_e, ext_e, shamt,
               fwd_d1, fwd_d2, fwd_d3, rs_fwd, rt_fwd,
               alu_asel, alu_bsel, alu_op, ov_chk, md_op, exc_e,
        input  ao_m, rt_m, exc_m, valid_m, md_busy, md_stall
    );

    modport slave (
        input  valid_e, flush, rs_e, rt_e, ext_e, shamt,
               fwd_d1, fwd_d2, fwd_d3, rs_fwd, rt_fwd,
               alu_asel, alu_bsel, alu_op, ov_chk, md_op, exc_e,
        output ao_m, rt_m, exc_m, valid_m, md_busy, md_stall
    );
endinterface

// File: rtl/ex_md_stage.sv
// ex_md_stage
// Execute stage of a MIPS-style pipeline: operand forwarding, ALU with
// overflow trap, a fixed-latency multiply/divide unit owning HI/LO, and the
// E/M pipeline register.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      ex_md_stage_if.slave: E-stage inputs in, E/M register,
//            md_busy and md_stall out
// Parameters: W (datapath width, even, >= 8), MUL_LAT / DIV_LAT (cycles
// from multiply / divide start until HI/LO hold the result, >= 1).
module ex_md_stage #(
    parameter int W       = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    ex_md_stage_if.slave bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    md_state_t      state;
    md_state_t      state_next;

    logic [W-1:0]   rs_val;
    logic [W-1:0]   rt_val;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   sum;
    logic [W-1:0]   diff;
    logic [W-1:0]   alu_out;
    logic [W-1:0]   result;
    logic           overflow;
    logic [4:0]     exc_code;
    logic           md_stall;
    logic           accepted;
    logic           md_start;
    logic           md_done;

    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [3:0]     op_kind;
    logic [CNT_W-1:0] count;

    logic           is_mul;
    logic           is_signed;
    logic           neg_a;
    logic           neg_b;
    logic [2*W-1:0] prod;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W-1:0]   mag_q;
    logic [W-1:0]   mag_r;
    logic [W-1:0]   res_hi;
    logic [W-1:0]   res_lo;

    logic [W-1:0]   ao_m;
    logic [W-1:0]   rt_m;
    logic [4:0]     exc_m;
    logic           valid_m;

    // Forwarding muxes; select 0 keeps the operand read in the D stage.
    always_comb begin
        rs_val = bus.rs_e;
        rt_val = bus.rt_e;
        case (bus.rs_fwd)
            2'd1:    rs_val = bus.fwd_d1;
            2'd2:    rs_val = bus.fwd_d2;
            2'd3:    rs_val = bus.fwd_d3;
            default: rs_val = bus.rs_e;
        endcase
        case (bus.rt_fwd)
            2'd1:    rt_val = bus.fwd_d1;
            2'd2:    rt_val = bus.fwd_d2;
            2'd3:    rt_val = bus.fwd_d3;
            default: rt_val = bus.rt_e;
        endcase
    end

    assign alu_a = bus.alu_asel ? {{(W-5){1'b0}}, bus.shamt} : rs_val;
    assign alu_b = bus.alu_bsel ? bus.ext_e : rt_val;
    assign sum   = alu_a + alu_b;
    assign diff  = alu_a - alu_b;

    // Shifts move B by the low five bits of A; unused opcodes yield zero.
    always_comb begin
        alu_out = '0;
        case (bus.alu_op)
            ALU_ADD:  alu_out = sum;
            ALU_SUB:  alu_out = diff;
            ALU_AND:  alu_out = alu_a & alu_b;
            ALU_OR:   alu_out = alu_a | alu_b;
            ALU_XOR:  alu_out = alu_a ^ alu_b;
            ALU_NOR:  alu_out = ~(alu_a | alu_b);
            ALU_SLL:  alu_out = alu_b << alu_a[4:0];
            ALU_SRL:  alu_out = alu_b >> alu_a[4:0];
            ALU_SRA:  alu_out = $signed(alu_b) >>> alu_a[4:0];
            ALU_SLT:  alu_out = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            ALU_SLTU: alu_out = {{(W-1){1'b0}}, (alu_a < alu_b)};
            ALU_LUI:  alu_out = alu_b << (W/2);
            default:  alu_out = '0;
        endcase
    end

    // Signed overflow: operands that agree in sign (add) or differ (sub)
    // produce a result whose sign differs from A.
    always_comb begin
        overflow = 1'b0;
        if (bus.alu_op == ALU_ADD) begin
            overflow = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
        end else if (bus.alu_op == ALU_SUB) begin
            overflow = (alu_a[W-1] != alu_b[W-1]) && (diff[W-1] != alu_a[W-1]);
        end
    end

    // An older exception keeps priority over the overflow trap.
    assign exc_code = (bus.ov_chk && overflow && (bus.exc_e == 5'd0)) ? EXC_OV : bus.exc_e;

    always_comb begin
        result = alu_out;
        if (bus.md_op == MD_MFHI) begin
            result = hi;
        end else if (bus.md_op == MD_MFLO) begin
            result = lo;
        end
    end

    // Any HI/LO instruction waits while the unit is busy, so a new operation
    // can only start from idle and mfhi/mflo never see a stale value.
    assign md_stall = bus.valid_e && (bus.md_op != MD_NONE) && (state == MD_BUSY);
    assign accepted = bus.valid_e && !bus.flush && !md_stall && (exc_code == 5'd0);
    assign md_start = accepted && (bus.md_op >= MD_MULT) && (bus.md_op <= MD_DIVU);
    assign md_done  = (state == MD_BUSY) && (count == CNT_W'(1));

    // Result generation from the operands captured at start. Division works
    // on magnitudes and fixes signs afterwards; min / -1 falls out naturally
    // because the magnitude of min is representable as an unsigned value.
    always_comb begin
        is_mul    = (op_kind == MD_MULT) || (op_kind == MD_MULTU);
        is_signed = (op_kind == MD_MULT) || (op_kind == MD_DIV);
        neg_a     = is_signed && op_a[W-1];
        neg_b     = is_signed && op_b[W-1];
        if (is_signed) begin
            prod = {{W{op_a[W-1]}}, op_a} * {{W{op_b[W-1]}}, op_b};
        end else begin
            prod = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
        end
        mag_a = neg_a ? -op_a : op_a;
        mag_b = neg_b ? -op_b : op_b;
        mag_q = (mag_b == '0) ? '0 : mag_a / mag_b;
        mag_r = (mag_b == '0) ? '0 : mag_a % mag_b;
        if (is_mul) begin
            res_hi = prod[2*W-1:W];
            res_lo = prod[W-1:0];
        end else if (op_b == '0) begin
            res_hi = op_a;
            res_lo = '1;
        end else begin
            res_hi = neg_a ? -mag_r : mag_r;
            res_lo = (neg_a ^ neg_b) ? -mag_q : mag_q;
        end
    end

    // Multiply/divide state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= MD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Busy until the countdown reaches its last cycle.
    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (md_start) state_next = MD_BUSY;
            MD_BUSY: if (md_done)  state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // Latency counter and operand capture at operation start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_kind <= MD_NONE;
        end else if (md_start) begin
            count   <= ((bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU)) ?
                       CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
            op_a    <= rs_val;
            op_b    <= rt_val;
            op_kind <= bus.md_op;
        end else if ((state == MD_BUSY) && (count != '0)) begin
            count   <= count - CNT_W'(1);
        end
    end

    // HI/LO: completion of the running operation, or a direct move.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (md_done) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (accepted && (bus.md_op == MD_MTHI)) begin
            hi <= rs_val;
        end else if (accepted && (bus.md_op == MD_MTLO)) begin
            lo <= rs_val;
        end
    end

    // E/M register; a stalled instruction leaves a bubble behind it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ao_m    <= '0;
            rt_m    <= '0;
            exc_m   <= 5'd0;
            valid_m <= 1'b0;
        end else if (md_stall) begin
            valid_m <= 1'b0;
        end else begin
            ao_m    <= result;
            rt_m    <= rt_val;
            exc_m   <= exc_code;
            valid_m <= bus.valid_e && !bus.flush;
        end
    end

    assign bus.ao_m     = ao_m;
    assign bus.rt_m     = rt_m;
    assign bus.exc_m    = exc_m;
    assign bus.valid_m  = valid_m;
    assign bus.md_busy  = (state == MD_BUSY);
    assign bus.md_stall = md_stall;
endmodule

// File: tb/tb_ex_md_stage.sv
// tb_ex_md_stage
// Directed bench for ex_md_stage (W=32, MUL_LAT=5, DIV_LAT=10). Each issued
// instruction queues its hand-computed E/M record; a monitor pops a record
// whenever the stage captures an instruction and compares it.
module tb_ex_md_stage;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic         vld;
        logic [4:0]   exc;
        logic [W-1:0] ao;
        logic [W-1:0] rt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    // 100 MHz-style clock, period 10.
    always #5 clk = ~clk;

    ex_md_stage_if #(.W(W)) bus ();

    ex_md_stage #(
        .W(W),
        .MUL_LAT(5),
        .DIV_LAT(10)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // Compare one value against its expectation and tally the result.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Return every E-stage input to a quiet, no-instruction state.
    task automatic idle_inputs();
        bus.valid_e  = 1'b0;
        bus.flush    = 1'b0;
        bus.rs_e     = '0;
        bus.rt_e     = '0;
        bus.ext_e    = '0;
        bus.shamt    = 5'd0;
        bus.fwd_d1   = '0;
        bus.fwd_d2   = '0;
        bus.fwd_d3   = '0;
        bus.rs_fwd   = 2'd0;
        bus.rt_fwd   = 2'd0;
        bus.alu_asel = 1'b0;
        bus.alu_bsel = 1'b0;
        bus.alu_op   = 4'd0;
        bus.ov_chk   = 1'b0;
        bus.md_op    = 4'd0;
        bus.exc_e    = 5'd0;
    endtask

    task automatic set_op(input logic [3:0] md, input logic [3:0] alu,
                          input logic [W-1:0] rs, input logic [W-1:0] rt);
        bus.md_op  = md;
        bus.alu_op = alu;
        bus.rs_e   = rs;
        bus.rt_e   = rt;
    endtask

    // Present the prepared instruction, queue its expected record, hold it
    // through any stall (bounded) and check the number of stall cycles.
    task automatic applyStimulus(input string name, input logic [W-1:0] exp_ao,
                                 input logic [W-1:0] exp_rt, input logic [4:0] exp_exc,
                                 input logic exp_vld, input int exp_stalls);
        int stalls;
        bit ok;
        stalls = 0;
        ok = 1'b0;
        exp_q.push_back({exp_vld, exp_exc, exp_ao, exp_rt});
        name_q.push_back(name);
        bus.valid_e = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!bus.md_stall) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL %s stall timeout: got %0d stall cycles, required %0d", name, stalls, exp_stalls);
        end else begin
            checkOutput({name, " stalls"}, 32'(stalls), 32'(exp_stalls));
        end
        @(posedge clk);
        #2;
        idle_inputs();
    endtask

    // Monitor: a capture happens on the edge after a negedge that saw an
    // unstalled valid instruction; its E/M record is checked one negedge later.
    initial begin : monitor
        exp_t  e;
        string nm;
        logic  pending;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("[TB] FAIL unexpected capture: got ao=%h, required no capture", bus.ao_m);
                    end else begin
                        e  = exp_q.pop_front();
                        nm = name_q.pop_front();
                        if ({bus.valid_m, bus.exc_m, bus.ao_m, bus.rt_m} !== e) begin
                            n_err++;
                            $display("[TB] FAIL %s: got valid=%b exc=%0d ao=%h rt=%h, required valid=%b exc=%0d ao=%h rt=%h",
                                     nm, bus.valid_m, bus.exc_m, bus.ao_m, bus.rt_m, e.vld, e.exc, e.ao, e.rt);
                        end
                    end
                end
                pending = bus.valid_e && !bus.md_stall;
            end
        end
    end

    // Hard stop if the sequence ever wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of sequence, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence; all inputs change 2 time units after a rising edge.
    initial begin
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset valid_m", 32'(bus.valid_m), 32'd0);
        checkOutput("reset ao_m", bus.ao_m, 32'd0);
        checkOutput("reset rt_m", bus.rt_m, 32'd0);
        checkOutput("reset exc_m", 32'(bus.exc_m), 32'd0);
        checkOutput("reset md_busy", 32'(bus.md_busy), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("post-reset md_busy", 32'(bus.md_busy), 32'd0);

        // ALU, forwarding and overflow trap
        set_op(4'd0, 4'd0, 32'h7FFF_FFFF, 32'd1); bus.ov_chk = 1'b1;
        applyStimulus("add ovf", 32'h8000_0000, 32'd1, 5'd12, 1'b1, 0);
        set_op(4'd0, 4'd0, 32'h7FFF_FFFF, 32'd1); bus.ov_chk = 1'b1; bus.exc_e = 5'd4;
        applyStimulus("add ovf exc4", 32'h8000_0000, 32'd1, 5'd4, 1'b1, 0);
        set_op(4'd0, 4'd0, 32'h7FFF_FFFF, 32'd1);
        applyStimulus("add no ovchk", 32'h8000_0000, 32'd1, 5'd0, 1'b1, 0);
        set_op(4'd0, 4'd0, 32'h100, 32'd7); bus.rs_fwd = 2'd3; bus.fwd_d3 = 32'd5;
        applyStimulus("fwd rs d3", 32'd12, 32'd7, 5'd0, 1'b1, 0);
        set_op(4'd0, 4'd1, 32'd3, 32'h999); bus.rt_fwd = 2'd1; bus.fwd_d1 = 32'd16; bus.ov_chk = 1'b1;
        applyStimulus("fwd rt d1 sub", 32'hFFFF_FFF3, 32'd16, 5'd0, 1'b1, 0);
        set_op(4'd0, 4'd1, 32'h8000_0000, 32'd1); bus.ov_chk = 1'b1;
        applyStimulus("sub ovf", 32'h7FFF_FFFF, 32'd1, 5'd12, 1'b1, 0);
        set_op(4'd0, 4'd6, 32'hFFFF, 32'd1); bus.alu_asel = 1'b1; bus.shamt = 5'd4;
        applyStimulus("sll shamt", 32'h10, 32'd1, 5'd0, 1'b1, 0);
        set_op(4'd0, 4'd8, 32'd0, 32'h8000_0000); bus.alu_asel = 1'b1; bus.shamt = 5'd8;
        applyStimulus("sra", 32'hFF80_0000, 32'h8000_0000, 5'd0, 1'b1, 0);
        set_op(4'd0, 4'd7, 32'd0, 32'h8000_0000); bus.rs_fwd = 2'd2; bus.fwd_d2 = 32'd8;
        applyStimulus("srl fwd d2", 32'h0080_0000, 32'h8000_0000, 5'd0, 1'b1, 0);
        set_op(4'd0, 4'd9, 32'hFFFF_FFFF, 32'd1);
        applyStimulus("slt", 32'd1, 32'd1, 5'd0, 1'b1, 0);
        set_op(4'd0, 4'd10, 32'hFFFF_FFFF, 32'd1);
        applyStimulus("sltu", 32'd0, 32'd1, 5'd0, 1'b1, 0);
        set_op(4'd0, 4'd11, 32'd0, 32'h77); bus.alu_bsel = 1'b1; bus.ext_e = 32'h1234;
        applyStimulus("lui", 32'h1234_0000, 32'h77, 5'd0, 1'b1, 0);
        set_op(4'd0, 4'd5, 32'hF0F0_F0F0, 32'h0F0F_0000);
        applyStimulus("nor", 32'h0000_0F0F, 32'h0F0F_0000, 5'd0, 1'b1, 0);
        set_op(4'd0, 4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0);
        applyStimulus("and", 32'h0F00_0F00, 32'h0FF0_0FF0, 5'd0, 1'b1, 0);
        set_op(4'd0, 4'd3, 32'hFF00_FF00, 32'h0FF0_0FF0);
        applyStimulus("or", 32'hFFF0_FFF0, 32'h0FF0_0FF0, 5'd0, 1'b1, 0);
        set_op(4'd0, 4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0);
        applyStimulus("xor", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 1'b1, 0);
        set_op(4'd0, 4'd12, 32'hFF00_FF00, 32'h0FF0_0FF0);
        applyStimulus("alu op12", 32'd0, 32'h0FF0_0FF0, 5'd0, 1'b1, 0);

        // Multiply
        set_op(4'd1, 4'd0, 32'hFFFF_FFFF, 32'd2);
        applyStimulus("mult", 32'd1, 32'd2, 5'd0, 1'b1, 0);
        checkOutput("mult md_busy", 32'(bus.md_busy), 32'd1);
        set_op(4'd7, 4'd0, 32'd0, 32'd0);
        applyStimulus("mfhi mult", 32'hFFFF_FFFF, 32'd0, 5'd0, 1'b1, 5);
        set_op(4'd8, 4'd0, 32'd0, 32'd0);
        applyStimulus("mflo mult", 32'hFFFF_FFFE, 32'd0, 5'd0, 1'b1, 0);
        set_op(4'd2, 4'd0, 32'hFFFF_FFFF, 32'd2);
        applyStimulus("multu", 32'd1, 32'd2, 5'd0, 1'b1, 0);
        set_op(4'd7, 4'd0, 32'd0, 32'd0);
        applyStimulus("mfhi multu", 32'd1, 32'd0, 5'd0, 1'b1, 5);

        // Divide
        set_op(4'd3, 4'd0, 32'hFFFF_FFF9, 32'd2);
        applyStimulus("div", 32'hFFFF_FFFB, 32'd2, 5'd0, 1'b1, 0);
        set_op(4'd8, 4'd0, 32'd0, 32'd0);
        applyStimulus("mflo div", 32'hFFFF_FFFD, 32'd0, 5'd0, 1'b1, 10);
        set_op(4'd7, 4'd0, 32'd0, 32'd0);
        applyStimulus("mfhi div", 32'hFFFF_FFFF, 32'd0, 5'd0, 1'b1, 0);
        set_op(4'd4, 4'd0, 32'd5, 32'd0);
        applyStimulus("divu by 0", 32'd5, 32'd0, 5'd0, 1'b1, 0);
        set_op(4'd8, 4'd0, 32'd0, 32'd0);
        applyStimulus("mflo divu0", 32'hFFFF_FFFF, 32'd0, 5'd0, 1'b1, 10);
        set_op(4'd7, 4'd0, 32'd0, 32'd0);
        applyStimulus("mfhi divu0", 32'd5, 32'd0, 5'd0, 1'b1, 0);
        set_op(4'd3, 4'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus("div min/-1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b1, 0);
        set_op(4'd8, 4'd0, 32'd0, 32'd0);
        applyStimulus("mflo min/-1", 32'h8000_0000, 32'd0, 5'd0, 1'b1, 10);
        set_op(4'd7, 4'd0, 32'd0, 32'd0);
        applyStimulus("mfhi min/-1", 32'd0, 32'd0, 5'd0, 1'b1, 0);

        // Direct moves into HI/LO
        set_op(4'd5, 4'd0, 32'hABCD, 32'd0);
        applyStimulus("mthi", 32'hABCD, 32'd0, 5'd0, 1'b1, 0);
        set_op(4'd7, 4'd0, 32'd0, 32'd0);
        applyStimulus("mfhi mthi", 32'hABCD, 32'd0, 5'd0, 1'b1, 0);
        set_op(4'd6, 4'd0, 32'd0, 32'd0); bus.rs_fwd = 2'd1; bus.fwd_d1 = 32'h55;
        applyStimulus("mtlo fwd", 32'h55, 32'd0, 5'd0, 1'b1, 0);
        set_op(4'd8, 4'd0, 32'd0, 32'd0);
        applyStimulus("mflo mtlo", 32'h55, 32'd0, 5'd0, 1'b1, 0);

        // Excepting or flushed operations never start
        set_op(4'd1, 4'd0, 32'd3, 32'd4); bus.exc_e = 5'd10;
        applyStimulus("mult exc10", 32'd7, 32'd4, 5'd10, 1'b1, 0);
        checkOutput("exc10 md_busy", 32'(bus.md_busy), 32'd0);
        set_op(4'd8, 4'd0, 32'd0, 32'd0);
        applyStimulus("mflo exc10", 32'h55, 32'd0, 5'd0, 1'b1, 0);
        set_op(4'd1, 4'd0, 32'd3, 32'd4); bus.flush = 1'b1;
        applyStimulus("mult flush", 32'd7, 32'd4, 5'd0, 1'b0, 0);
        checkOutput("flush md_busy", 32'(bus.md_busy), 32'd0);
        set_op(4'd7, 4'd0, 32'd0, 32'd0);
        applyStimulus("mfhi flush", 32'hABCD, 32'd0, 5'd0, 1'b1, 0);
        set_op(4'd1, 4'd0, 32'h7FFF_FFFF, 32'd1); bus.ov_chk = 1'b1;
        applyStimulus("mult ovtrap", 32'h8000_0000, 32'd1, 5'd12, 1'b1, 0);
        checkOutput("ovtrap md_busy", 32'(bus.md_busy), 32'd0);

        // A younger flush does not abort the running multiply
        set_op(4'd1, 4'd0, 32'd3, 32'd4);
        applyStimulus("mult inflight", 32'd7, 32'd4, 5'd0, 1'b1, 0);
        set_op(4'd0, 4'd0, 32'd1, 32'd1); bus.flush = 1'b1;
        applyStimulus("flush younger", 32'd2, 32'd1, 5'd0, 1'b0, 0);
        set_op(4'd8, 4'd0, 32'd0, 32'd0);
        applyStimulus("mflo inflight", 32'd12, 32'd0, 5'd0, 1'b1, 4);
        set_op(4'd7, 4'd0, 32'd0, 32'd0);
        applyStimulus("mfhi inflight", 32'd0, 32'd0, 5'd0, 1'b1, 0);

        // Reset in the middle of a divide
        set_op(4'd3, 4'd0, 32'd100, 32'd7);
        applyStimulus("div pre-reset", 32'd107, 32'd7, 5'd0, 1'b1, 0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("div busy pre-reset", 32'(bus.md_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("async md_busy", 32'(bus.md_busy), 32'd0);
        checkOutput("async ao_m", bus.ao_m, 32'd0);
        checkOutput("async valid_m", 32'(bus.valid_m), 32'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        set_op(4'd8, 4'd0, 32'd0, 32'd0);
        applyStimulus("mflo after reset", 32'd0, 32'd0, 5'd0, 1'b1, 0);
        set_op(4'd7, 4'd0, 32'd0, 32'd0);
        applyStimulus("mfhi after reset", 32'd0, 32'd0, 5'd0, 1'b1, 0);

        repeat (3) @(posedge clk);
        #2;
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
